floating_point_rounding: RTL and testbench

Stage5 of the floating-point add/sub datapath. Consumes the normalized sign/exponent/mentissa plus guard/round/sticky bits from the stage4 normalizer. Applies IEEE-754 rounding in one of four modes. Returns the packed single-precision result through a 2-stage valid/ready pipeline with backpressure.

---
 rtl/floating_point_rounding.sv | 159 +++++++++++++++
 tb/tb_floating_point_rounding.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/floating_point_rounding.sv
// Add/sub stage5: IEEE-754 rounding (RNE/RTZ/+inf/-inf), 2-stage valid/ready pipe.
// Optional sticky inexact/overflow flags when ROUNDING_FLAGS_EN is defined.
module floating_point_rounding #(
  parameter int DATA_WIDTH = 32,
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic                  sign_in,
  input  logic [EXPO_WIDTH-1:0] exponent_in,
  input  logic [MENT_WIDTH-1:0] mentissa_in,
  input  logic [2:0]            grs_in,
  input  logic [1:0]            rounding_mode_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] floating_rounded_out
`ifdef ROUNDING_FLAGS_EN
  ,
  input  logic                  flags_clear_in,
  output logic                  inexact_flag_out,
  output logic                  overflow_flag_out
`endif
);

  localparam int EM = EXPO_WIDTH + MENT_WIDTH;

  logic          w_s2_adv;
  logic          w_s1_adv;
  logic          w_xfer_in;
  logic          w_xfer_out;
  logic          w_g;
  logic          w_r;
  logic          w_s;
  logic          w_any;
  logic          w_special;
  logic          w_inc;
  logic [EM-1:0] w_sum;

  logic          r_s1_valid;
  logic          r_s1_sign;
  logic [EM-1:0] r_s1_em;
  logic          r_s1_inc;
  logic          r_s2_valid;
  logic [DATA_WIDTH-1:0] r_out;

  assign w_g        = grs_in[2];
  assign w_r        = grs_in[1];
  assign w_s        = grs_in[0];
  assign w_any      = |grs_in;
  assign w_special  = &exponent_in;

  assign w_s2_adv   = ~r_s2_valid | ready_in;
  assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
  assign w_xfer_in  = valid_in & w_s1_adv;
  assign w_xfer_out = r_s2_valid & ready_in;

  assign ready_out  = w_s1_adv;
  assign valid_out  = r_s2_valid;
  assign floating_rounded_out = r_out;

  // The increment is a single carry into {exp,frac}; carries ripple into the exponent.
  assign w_sum = r_s1_em + EM'(r_s1_inc);

  // Round-up decision per mode; Inf/NaN operands never round.
  always_comb begin
    w_inc = 1'b0;
    unique case (rounding_mode_in)
      2'b00: w_inc = w_g & (w_r | w_s | mentissa_in[0]);
      2'b01: w_inc = 1'b0;
      2'b10: w_inc = ~sign_in & w_any;
      2'b11: w_inc = sign_in & w_any;
      default: w_inc = 1'b0;
    endcase
    if (w_special) w_inc = 1'b0;
  end

  // S1: capture operand and rounding decision.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_em    <= '0;
      r_s1_inc   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= valid_in;
      if (w_xfer_in) begin
        r_s1_sign <= sign_in;
        r_s1_em   <= {exponent_in, mentissa_in};
        r_s1_inc  <= w_inc;
      end
    end
  end

  // S2: apply increment; data holds while empty or stalled.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s2_valid <= 1'b0;
      r_out      <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_out <= {r_s1_sign, w_sum};
    end
  end

`ifdef ROUNDING_FLAGS_EN
  logic r_s1_inexact;
  logic r_s1_special;
  logic r_s2_inexact;
  logic r_s2_special;
  logic r_inexact_flag;
  logic r_overflow_flag;
  logic w_ovf;

  assign w_ovf = (&r_out[DATA_WIDTH-2 -: EXPO_WIDTH]) & ~r_s2_special;
  assign inexact_flag_out  = r_inexact_flag;
  assign overflow_flag_out = r_overflow_flag;

  // Side-band status travelling alongside the datapath.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1_inexact <= 1'b0;
      r_s1_special <= 1'b0;
      r_s2_inexact <= 1'b0;
      r_s2_special <= 1'b0;
    end else begin
      if (w_xfer_in) begin
        r_s1_inexact <= w_any & ~w_special;
        r_s1_special <= w_special;
      end
      if (w_s2_adv & r_s1_valid) begin
        r_s2_inexact <= r_s1_inexact;
        r_s2_special <= r_s1_special;
      end
    end
  end

  // Sticky flags; a set on an output transfer beats a same-cycle clear.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_inexact_flag  <= 1'b0;
      r_overflow_flag <= 1'b0;
    end else begin
      if (flags_clear_in) begin
        r_inexact_flag  <= 1'b0;
        r_overflow_flag <= 1'b0;
      end
      if (w_xfer_out & r_s2_inexact) r_inexact_flag  <= 1'b1;
      if (w_xfer_out & w_ovf)        r_overflow_flag <= 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused = w_xfer_out;
`endif

endmodule

// File: tb/tb_floating_point_rounding.sv
// Bench for floating_point_rounding: directed + random vs scoreboard model.
module tb_floating_point_rounding;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    logic [2:0]  g;
    logic [1:0]  m;
  } op_t;

  typedef struct {
    logic [31:0] res;
    logic        inx;
    logic        ovf;
    int          acc;
    bit          dir;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic        ready_out;
  logic        sign_in;
  logic [7:0]  exponent_in;
  logic [22:0] mentissa_in;
  logic [2:0]  grs_in;
  logic [1:0]  rounding_mode_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] floating_rounded_out;
`ifdef ROUNDING_FLAGS_EN
  logic        flags_clear_in;
  logic        inexact_flag_out;
  logic        overflow_flag_out;
`endif

  always #5 clk_in = ~clk_in;

  floating_point_rounding dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .valid_in             (valid_in),
    .ready_out            (ready_out),
    .sign_in              (sign_in),
    .exponent_in          (exponent_in),
    .mentissa_in          (mentissa_in),
    .grs_in               (grs_in),
    .rounding_mode_in     (rounding_mode_in),
    .valid_out            (valid_out),
    .ready_in             (ready_in),
    .floating_rounded_out (floating_rounded_out)
`ifdef ROUNDING_FLAGS_EN
    ,
    .flags_clear_in       (flags_clear_in),
    .inexact_flag_out     (inexact_flag_out),
    .overflow_flag_out    (overflow_flag_out)
`endif
  );

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_out;
  bit          mf_inx;
  bit          mf_ovf;

  always @(posedge clk_in) cyc++;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference rounding: value = {exp,frac} + grs/8 ulp, rounded to an integer ulp.
  function automatic logic [31:0] ref_round(input op_t o);
    int unsigned mag;
    int unsigned rem;
    bit          up;
    mag = {1'b0, o.e, o.f};
    rem = o.g;
    if (o.e == 8'hFF) return {o.s, o.e, o.f};
    case (o.m)
      2'd0: up = (rem > 4) || (rem == 4 && (mag % 2) == 1);
      2'd1: up = 0;
      2'd2: up = !o.s && rem != 0;
      default: up = o.s && rem != 0;
    endcase
    mag = mag + (up ? 1 : 0);
    return {o.s, mag[30:0]};
  endfunction

  task automatic step(input op_t op, input bit v, input bit rdy,
                      input bit clr, input bit dir,
                      input logic [31:0] dres,
                      output bit xi, output bit xo);
    exp_t e;
    @(negedge clk_in);
    valid_in         = v;
    sign_in          = op.s;
    exponent_in      = op.e;
    mentissa_in      = op.f;
    grs_in           = op.g;
    rounding_mode_in = op.m;
    ready_in         = rdy;
`ifdef ROUNDING_FLAGS_EN
    flags_clear_in   = clr;
`endif
    #1;
    chk("ready_out", ready_out, (q.size() < 2) || rdy);
    if (q.size() == 0) chk("idle_valid", valid_out, 1'b0);
    if (valid_out && q.size() > 0) begin
      chk("result", floating_rounded_out, q[0].res);
      last_out = floating_rounded_out;
    end else if (!valid_out) begin
      chk("hold", floating_rounded_out, last_out);
    end
`ifdef ROUNDING_FLAGS_EN
    chk("inexact_flag", inexact_flag_out, mf_inx);
    chk("overflow_flag", overflow_flag_out, mf_ovf);
`endif
    xo = valid_out && rdy;
    xi = v && ready_out;
    if (clr) begin
      mf_inx = 0;
      mf_ovf = 0;
    end
    if (xo && q.size() > 0) begin
      e = q.pop_front();
      if (e.dir) chk("latency", cyc - e.acc, 2);
      if (e.inx) mf_inx = 1;
      if (e.ovf) mf_ovf = 1;
    end
    if (xi) begin
      e.res = dir ? dres : ref_round(op);
      e.inx = (op.g != 0) && (op.e != 8'hFF);
      e.ovf = (e.res[30:23] == 8'hFF) && (op.e != 8'hFF);
      e.acc = cyc;
      e.dir = dir;
      q.push_back(e);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk_in);
    rst_in   = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
`ifdef ROUNDING_FLAGS_EN
    flags_clear_in = 1'b0;
`endif
    @(negedge clk_in);
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_data", floating_rounded_out, 32'h0);
    chk("rst_ready_out", ready_out, 1'b1);
`ifdef ROUNDING_FLAGS_EN
    chk("rst_inexact", inexact_flag_out, 1'b0);
    chk("rst_overflow", overflow_flag_out, 1'b0);
`endif
    rst_in = 1'b0;
    q.delete();
    last_out = 32'h0;
    mf_inx = 0;
    mf_ovf = 0;
  endtask

  task automatic directed(input op_t op, input logic [31:0] res);
    bit xi;
    bit xo;
    op_t idle;
    idle = '0;
    step(op, 1, 1, 0, 1, res, xi, xo);
    if (!xi) chk("dir_accept", xi, 1'b1);
    for (int i = 0; i < 3; i++) step(idle, 0, 1, 0, 0, 0, xi, xo);
  endtask

  op_t ops[3];
  op_t idle;
  op_t rop;
  bit  xi;
  bit  xo;
  int  idx;
  int  nout;

  initial begin
    idle = '0;
    rst_in = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    sign_in = 1'b0;
    exponent_in = '0;
    mentissa_in = '0;
    grs_in = '0;
    rounding_mode_in = '0;
`ifdef ROUNDING_FLAGS_EN
    flags_clear_in = 1'b0;
`endif
    last_out = 32'h0;
    repeat (2) @(posedge clk_in);
    reset_dut();

    directed('{1'b0, 8'h7F, 23'h000000, 3'b100, 2'd0}, 32'h3F800000);
    directed('{1'b0, 8'h7F, 23'h000001, 3'b100, 2'd0}, 32'h3F800002);
    directed('{1'b0, 8'h7F, 23'h000001, 3'b100, 2'd1}, 32'h3F800001);
    directed('{1'b0, 8'h7F, 23'h7FFFFF, 3'b110, 2'd0}, 32'h40000000);
    directed('{1'b0, 8'h00, 23'h7FFFFF, 3'b100, 2'd0}, 32'h00800000);
    directed('{1'b0, 8'hFE, 23'h7FFFFF, 3'b100, 2'd0}, 32'h7F800000);
    directed('{1'b1, 8'hFE, 23'h7FFFFF, 3'b001, 2'd3}, 32'hFF800000);
    directed('{1'b1, 8'h80, 23'h000000, 3'b001, 2'd3}, 32'hC0000001);
    directed('{1'b1, 8'h80, 23'h000000, 3'b001, 2'd2}, 32'hC0000000);
    directed('{1'b0, 8'hFF, 23'h400000, 3'b111, 2'd0}, 32'h7FC00000);
`ifdef ROUNDING_FLAGS_EN
    chk("ovf_after_fe", overflow_flag_out, 1'b1);
    step(idle, 0, 1, 1, 0, 0, xi, xo);
    step(idle, 0, 1, 0, 0, 0, xi, xo);
    directed('{1'b0, 8'hFF, 23'h400000, 3'b111, 2'd0}, 32'h7FC00000);
    chk("nan_no_inexact", inexact_flag_out, 1'b0);
`endif

    // Backpressure: A,B,C offered with downstream stalled for 4 cycles.
    ops[0] = '{1'b0, 8'h10, 23'h000AAA, 3'b000, 2'd0};
    ops[1] = '{1'b1, 8'h20, 23'h000BBB, 3'b111, 2'd1};
    ops[2] = '{1'b0, 8'h30, 23'h000CCD, 3'b100, 2'd0};
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      step(ops[idx], 1, 0, 0, 0, 0, xi, xo);
      if (xi) idx++;
    end
    chk("bp_accepted", idx, 2);
    chk("bp_ready_low", ready_out, 1'b0);
    nout = 0;
    for (int i = 0; i < 3; i++) begin
      step(ops[idx < 3 ? idx : 2], idx < 3, 1, 0, 0, 0, xi, xo);
      if (xi) idx++;
      if (xo) nout++;
    end
    chk("bp_back_to_back", nout, 3);
    for (int i = 0; i < 2; i++) step(idle, 0, 1, 0, 0, 0, xi, xo);

    // Reset with both stages full: nothing stale may emerge afterwards.
    step(ops[0], 1, 0, 0, 0, 0, xi, xo);
    step(ops[1], 1, 0, 0, 0, 0, xi, xo);
    chk("full_before_rst", q.size(), 2);
    reset_dut();
    for (int i = 0; i < 5; i++) step(idle, 0, 1, 0, 0, 0, xi, xo);

    // Randomized traffic with random backpressure and flag clears.
    for (int i = 0; i < 800; i++) begin
      rop.s = 1'($urandom);
      case ($urandom_range(0, 9))
        0: rop.e = 8'hFE;
        1: rop.e = 8'hFF;
        2: rop.e = 8'h00;
        default: rop.e = 8'($urandom);
      endcase
      rop.f = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
      rop.g = 3'($urandom);
      rop.m = 2'($urandom);
      step(rop, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0, 0, 0, xi, xo);
    end
    for (int i = 0; i < 6; i++) step(idle, 0, 1, 0, 0, 0, xi, xo);
    chk("drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
